// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-requester nibble-serial ALU scheduler.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] ADD  = 4'b0000;
  localparam logic [3:0] SUB  = 4'b1000;
  localparam logic [3:0] SLT  = 4'b0010;
  localparam logic [3:0] SLTU = 4'b0011;
  localparam logic [3:0] XOR  = 4'b0100;
  localparam logic [3:0] OR   = 4'b0110;
  localparam logic [3:0] AND  = 4'b0111;

  localparam logic [2:0] NIBBLE_LAST = 3'd7;

endpackage

// File: rtl/tiny45_alu.sv
// 4-bit ALU slice: add/sub with carry chaining, logic ops, and a compare chain
// (equality for non-compare ops, less-than at the top nibble for SLT/SLTU).
module tiny45_alu (
  input  logic [3:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cy_in,
  input  logic       cmp_in,
  output logic [3:0] d,
  output logic       cy_out,
  output logic       cmp_out
);

  logic       sub;
  logic [3:0] bx;
  logic [4:0] sum;

  always_comb begin
    sub     = op[3] | (op[2:1] == 2'b01);
    bx      = sub ? ~b : b;
    sum     = {1'b0, a} + {1'b0, bx} + {4'b0000, cy_in};
    d       = '0;
    cy_out  = 1'b0;
    cmp_out = cmp_in & (a == b);
    case (op[2:0])
      3'b000: begin
        d      = sum[3:0];
        cy_out = sum[4];
      end
      // Compare ops leave d at zero; the scheduler patches bit 0 afterwards.
      3'b010: begin
        cy_out  = sum[4];
        cmp_out = (a[3] ^ b[3]) ? a[3] : ~sum[4];
      end
      3'b011: begin
        cy_out  = sum[4];
        cmp_out = ~sum[4];
      end
      3'b100:  d = a ^ b;
      3'b110:  d = a | b;
      3'b111:  d = a & b;
      default: d = '0;
    endcase
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin (or fixed-priority) scheduler feeding 32-bit operations through
// the 4-bit tiny45_alu slice over 8 cycles, with a held result port.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int unsigned RR_EN = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [3:0]  r0_op,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [3:0]  r1_op,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic [31:0] res_d,
  output logic        res_cmp
);

  state_t      state, state_nx;
  logic [2:0]  n;
  logic        last;
  logic [3:0]  op_r;
  logic [31:0] a_r, b_r;
  logic        cy_reg, cmp_reg;
  logic        grant_any, grant_id, take;

  logic [3:0]  s_a, s_b, s_d;
  logic        s_cy_in, s_cmp_in, s_cy_out, s_cmp_out;

  always_comb begin
    grant_any = r0_valid | r1_valid;
    if (r0_valid && r1_valid) grant_id = (RR_EN != 0) ? ~last : 1'b0;
    else                      grant_id = r1_valid;
  end

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    case (state)
      IDLE: if (rstn && grant_any) begin
        take     = 1'b1;
        state_nx = RUN;
      end
      RUN:  if (n == NIBBLE_LAST) state_nx = DONE;
      DONE: if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    r0_ready  = take & ~grant_id;
    r1_ready  = take & grant_id;
    res_valid = (state == DONE);
  end

  always_comb begin
    s_a      = a_r[{n, 2'b00} +: 4];
    s_b      = b_r[{n, 2'b00} +: 4];
    s_cy_in  = (n == 3'd0) ? (op_r[1] | op_r[3]) : cy_reg;
    s_cmp_in = (n == 3'd0) ? 1'b1 : cmp_reg;
  end

  tiny45_alu u_slice (
    .op      (op_r),
    .a       (s_a),
    .b       (s_b),
    .cy_in   (s_cy_in),
    .cmp_in  (s_cmp_in),
    .d       (s_d),
    .cy_out  (s_cy_out),
    .cmp_out (s_cmp_out)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      n       <= '0;
      last    <= 1'b1;
      op_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      cy_reg  <= 1'b0;
      cmp_reg <= 1'b0;
      res_id  <= 1'b0;
      res_d   <= '0;
      res_cmp <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        op_r   <= grant_id ? r1_op : r0_op;
        a_r    <= grant_id ? r1_a : r0_a;
        b_r    <= grant_id ? r1_b : r0_b;
        res_id <= grant_id;
        last   <= grant_id;
        n      <= '0;
      end
      if (state == RUN) begin
        res_d[{n, 2'b00} +: 4] <= s_d;
        cy_reg  <= s_cy_out;
        cmp_reg <= s_cmp_out;
        // n wraps 7->0 exactly as the FSM leaves RUN.
        n       <= n + 3'd1;
        if (n == NIBBLE_LAST) begin
          res_cmp <= s_cmp_out;
          if (op_r[2:1] == 2'b01) res_d[0] <= s_cmp_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed vector table, multi-cycle corner
// sequences, and randomized ops against an arithmetic reference model.
module tb_alu_sched;
  import alu_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        r0_valid, r1_valid, res_ready;
  logic        r0_ready, r1_ready;
  logic [3:0]  r0_op, r1_op;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic        res_valid, res_id, res_cmp;
  logic [31:0] res_d;
  logic        f_r0_ready, f_r1_ready, f_res_valid, f_res_id, f_res_cmp;
  logic [31:0] f_res_d;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_sched #(.RR_EN(1)) dut (
    .clk(clk), .rstn(rstn),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_d(res_d), .res_cmp(res_cmp)
  );

  alu_sched #(.RR_EN(0)) dut_fp (
    .clk(clk), .rstn(rstn),
    .r0_valid(r0_valid), .r0_ready(f_r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(f_r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .res_valid(f_res_valid), .res_ready(res_ready), .res_id(f_res_id),
    .res_d(f_res_d), .res_cmp(f_res_cmp)
  );

  typedef struct {
    logic        id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        cmp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic straight from the op definitions.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] d, output logic cmp);
    d   = '0;
    cmp = (a == b);
    case (op)
      ADD:  d = a + b;
      SUB:  d = a - b;
      SLT:  begin cmp = ($signed(a) < $signed(b)); d = {31'b0, cmp}; end
      SLTU: begin cmp = (a < b); d = {31'b0, cmp}; end
      XOR:  d = a ^ b;
      OR:   d = a | b;
      AND:  d = a & b;
      default: d = '0;
    endcase
  endfunction

  task automatic set_req(input logic id, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (id) begin r1_valid = v; r1_op = op; r1_a = a; r1_b = b; end
    else    begin r0_valid = v; r0_op = op; r0_a = a; r0_b = b; end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic wait_grant(input logic id, output logic got);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = id ? r1_ready : r0_ready;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_result(output int lat);
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(negedge clk);
      if (res_valid) lat = i;
    end
  endtask

  task automatic run_op(input string tag, input logic id, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic exp_cmp);
    logic got;
    int   lat;
    set_req(id, 1'b1, op, a, b);
    wait_grant(id, got);
    set_req(id, 1'b0, op, a, b);
    chk1({tag, "_grant"}, got, 1'b1);
    if (!got) return;
    wait_result(lat);
    chk({tag, "_latency"}, lat, 32'd9);
    chk({tag, "_d"}, res_d, exp_d);
    chk1({tag, "_cmp"}, res_cmp, exp_cmp);
    chk1({tag, "_id"}, res_id, id);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    chk1({tag, "_released"}, res_valid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[11];
    logic        got;
    int          lat;
    int          g0, g1, dut_r0, dut_r1, fp_r0, fp_r1;
    int          rc[$];
    logic [31:0] rd[$];
    logic        ri[$];
    logic [3:0]  ops[7];
    logic [3:0]  op;
    logic [31:0] a, b, ed;
    logic        ec, id;

    vecs[0]  = '{1'b0, ADD,  32'h00000005, 32'h00000007, 32'h0000000C, 1'b0};
    vecs[1]  = '{1'b1, SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{1'b0, SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1};
    vecs[3]  = '{1'b1, SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[4]  = '{1'b0, AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vecs[5]  = '{1'b1, XOR,  32'h12345678, 32'h12345678, 32'h00000000, 1'b1};
    vecs[6]  = '{1'b0, OR,   32'h0F0F0000, 32'h00F0000F, 32'h0FFF000F, 1'b0};
    vecs[7]  = '{1'b1, ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b0, SLT,  32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b1};
    vecs[9]  = '{1'b1, SLTU, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 1'b0};
    vecs[10] = '{1'b0, SLT,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
    ops = '{ADD, SUB, SLT, SLTU, XOR, OR, AND};

    res_ready = 1'b0;
    set_req(1'b0, 1'b1, ADD, 32'h1, 32'h1);
    set_req(1'b1, 1'b1, ADD, 32'h2, 32'h2);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_r0_ready", r0_ready, 1'b0);
    chk1("rst_r1_ready", r1_ready, 1'b0);
    chk1("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_d", res_d, 32'h0);
    chk1("rst_res_cmp", res_cmp, 1'b0);
    chk1("rst_res_id", res_id, 1'b0);
    set_req(1'b0, 1'b0, ADD, '0, '0);
    set_req(1'b1, 1'b0, ADD, '0, '0);
    @(posedge clk);
    #1 rstn = 1'b1;

    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].d, vecs[i].cmp);

    // Backpressure: result held while res_ready is low; r1 waits until IDLE.
    set_req(1'b0, 1'b1, ADD, 32'h10, 32'h20);
    wait_grant(1'b0, got);
    set_req(1'b0, 1'b0, ADD, 32'h10, 32'h20);
    chk1("bp_grant", got, 1'b1);
    wait_result(lat);
    chk("bp_latency", lat, 32'd9);
    set_req(1'b1, 1'b1, XOR, 32'hA5A5A5A5, 32'h0F0F0F0F);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("bp_valid", res_valid, 1'b1);
      chk("bp_d", res_d, 32'h00000030);
      chk("bp_readys", {30'b0, r0_ready, r1_ready}, 32'h0);
      if (i < 4) begin @(posedge clk); #1; end
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    chk1("bp_idle_valid", res_valid, 1'b0);
    chk1("bp_r1_grant", r1_ready, 1'b1);
    @(posedge clk);
    #1 set_req(1'b1, 1'b0, AND, 32'hDEADBEEF, 32'h12345678);
    wait_result(lat);
    chk("bp_r1_latency", lat, 32'd9);
    chk("bp_r1_d", res_d, 32'hAAAAAAAA);
    chk1("bp_r1_id", res_id, 1'b1);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;

    // Both requesters valid from reset, consumer always ready.
    do_reset();
    set_req(1'b0, 1'b1, ADD, 32'h1, 32'h1);
    set_req(1'b1, 1'b1, ADD, 32'h2, 32'h2);
    res_ready = 1'b1;
    g0 = -1;
    g1 = -1;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if (r0_ready && g0 < 0) g0 = c;
      if (r1_ready && g1 < 0) g1 = c;
      if (res_valid) begin rc.push_back(c); rd.push_back(res_d); ri.push_back(res_id); end
      @(posedge clk);
      #1;
      if (g0 >= 0) r0_valid = 1'b0;
      if (g1 >= 0) r1_valid = 1'b0;
    end
    chk("rr_grant0_cycle", g0, 32'd0);
    chk("rr_grant1_cycle", g1, 32'd10);
    chk("rr_result_count", rc.size(), 32'd2);
    if (rc.size() == 2) begin
      chk("rr_res0_cycle", rc[0], 32'd9);
      chk("rr_res0_d", rd[0], 32'h2);
      chk1("rr_res0_id", ri[0], 1'b0);
      chk("rr_res1_cycle", rc[1], 32'd19);
      chk("rr_res1_d", rd[1], 32'h4);
      chk1("rr_res1_id", ri[1], 1'b1);
    end

    // Continuous contention: round-robin alternates, fixed priority starves r1.
    do_reset();
    set_req(1'b0, 1'b1, ADD, 32'h1, 32'h1);
    set_req(1'b1, 1'b1, ADD, 32'h2, 32'h2);
    dut_r0 = 0; dut_r1 = 0; fp_r0 = 0; fp_r1 = 0;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      dut_r0 += int'(r0_ready);
      dut_r1 += int'(r1_ready);
      fp_r0  += int'(f_r0_ready);
      fp_r1  += int'(f_r1_ready);
    end
    chk("rr_r0_grants", dut_r0, 32'd2);
    chk("rr_r1_grants", dut_r1, 32'd2);
    chk("fp_r0_grants", fp_r0, 32'd4);
    chk("fp_r1_grants", fp_r1, 32'd0);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, ADD, '0, '0);
    set_req(1'b1, 1'b0, ADD, '0, '0);
    res_ready = 1'b0;
    do_reset();

    // Reset while the slice is on nibble 4: in-flight op must vanish.
    set_req(1'b1, 1'b1, SUB, 32'h3, 32'h5);
    wait_grant(1'b1, got);
    set_req(1'b1, 1'b0, SUB, 32'h3, 32'h5);
    chk1("mr_grant", got, 1'b1);
    repeat (4) @(posedge clk);
    #1 rstn = 1'b0;
    set_req(1'b0, 1'b1, AND, 32'hF0F0F0F0, 32'hFF00FF00);
    @(negedge clk);
    chk1("mr_ready_in_reset", r0_ready, 1'b0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk1("mr_res_valid", res_valid, 1'b0);
    chk1("mr_idle_grant", r0_ready, 1'b1);
    @(posedge clk);
    #1 set_req(1'b0, 1'b0, AND, '0, '0);
    wait_result(lat);
    chk("mr_latency", lat, 32'd9);
    chk("mr_d", res_d, 32'hF000F000);
    chk1("mr_id", res_id, 1'b0);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 6)];
      id = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = 32'($urandom_range(0, 15));
        2:       b = a ^ 32'h80000000;
        default: b = $urandom;
      endcase
      model(op, a, b, ed, ec);
      run_op($sformatf("rnd%0d", i), id, op, a, b, ed, ec);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Two-requester scheduler for the shared nibble-serial ALU slice `tiny45_alu`. It accepts whole 32-bit operations from two clients over valid/ready handshakes and arbitrates round-robin between them. Each accepted operation is sequenced through the 4-bit slice over 8 cycles, LSB nibble first, with carry and compare chaining and the SLT/SLTU result fix-up. The 32-bit result is returned on a held valid/ready result port tagged with the requester id.

## Interface
Parameters:
- RR_EN, default 1: 1 = round-robin arbitration; 0 = fixed priority, requester 0 wins.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- r0_valid  in  1  requester 0 has an operation
- r0_ready  out  1  requester 0 operation accepted this cycle
- r0_op  in  4  ALU op: {funct7[5], funct3}
- r0_a, r0_b  in  32  operands
- r1_valid, r1_ready, r1_op, r1_a, r1_b: same as requester 0, for requester 1
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_id  out  1  requester that issued the result
- res_d  out  32  result word
- res_cmp  out  1  final compare flag (cmp_out of nibble 7)

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE:
  - If any valid, grant one requester.
  - Assert its ready combinationally in the same cycle.
  - Latch op, a, b and id.
  - Clear nibble counter `n`; go to RUN.
  - Ready is never asserted outside IDLE.
- Arbitration:
  - Single valid wins.
  - Both valid with RR_EN=1: grant the requester not granted last (`last` flag).
  - Both valid with RR_EN=0: requester 0 wins.
  - `last` updates only on a grant.
- RUN, nibble n = 0..7:
  - Drive slice with op, a[4n+:4], b[4n+:4].
  - cy_in = (n==0) ? (op[1] | op[3]) : cy_reg.
  - cmp_in = (n==0) ? 1 : cmp_reg.
  - Register slice d into res_d[4n+:4]; register cy_out into cy_reg and cmp_out into cmp_reg.
  - At n==7: if op[2:1]==2'b01 (SLT/SLTU), res_d[0] = cmp_out, overriding the slice bit. res_cmp = cmp_out. Go to DONE.
- DONE:
  - res_valid=1; res_d, res_cmp and res_id stay stable.
  - res_ready=1 → IDLE.
  - DONE→IDLE costs one cycle; no grant is made in DONE.
- Counter is 3 bits and wraps only via the state transition; it is never free-running.
- Requester inputs are sampled only at grant; later changes have no effect.

## Timing
- Reset values: state IDLE, n=0, last=1 (requester 0 first), res_valid=0, res_d=0, res_cmp=0, res_id=0, cy_reg=0, cmp_reg=0, r0_ready=r1_ready=0 while rstn=0.
- Accept at cycle T (valid & ready high):
  - RUN occupies T+1..T+8.
  - res_valid is high from T+9.
- With res_ready held high:
  - Accepted T, result T+9, back in IDLE at T+10.
  - Next grant at T+10.
  - Back-to-back issue interval is 10 cycles.
- Backpressure: res_valid stays high and outputs are frozen until res_ready. No new grant while in DONE.
- A requester whose valid drops before grant is simply not granted; no error.
- Reset mid-RUN or mid-DONE:
  - Next edge forces IDLE and clears res_valid.
  - The in-flight operation is discarded; no result is delivered.

## Structure
- Package `alu_sched_pkg`:
  - State enum (IDLE/RUN/DONE).
  - Op constants: ADD=4'b0000, SUB=4'b1000, SLT=4'b0010, SLTU=4'b0011, XOR=4'b0100, OR=4'b0110, AND=4'b0111.
  - NIBBLE_LAST=3'd7.
- Sub-module: one instance of the existing `tiny45_alu` slice. Arbitration and sequencing stay inline.

## Test plan
- ADD: r0 op 0000, a=0x00000005, b=0x00000007, res_ready=1.
  - r0_ready at T; res_valid at T+9.
  - res_d=0x0000000C, res_id=0.
- SUB: r1 op 1000, a=3, b=5 → res_d=0xFFFFFFFE, res_id=1.
- SLT/SLTU fix-up, a=0xFFFFFFFF, b=1:
  - op 0010 → res_d=0x00000001.
  - op 0011 → res_d=0x00000000.
- Both valid from reset, ops ADD 1+1 (r0) and ADD 2+2 (r1):
  - First grant r0 → 2; second grant r1 → 4, issued at T+10.
  - With RR_EN=0 and r0 kept valid, r1 is never granted.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid.
  - res_d stable; both readys low; r1_valid ignored.
  - res_ready=1 → IDLE next cycle, then r1 granted.
- Reset at n=4 of RUN:
  - Next cycle state IDLE, res_valid=0, no result delivered.
  - Next request (AND 0xF0F0F0F0 & 0xFF00FF00) → 0xF000F000 from requester 0.
